// File: rtl/ascii2scan_tx.sv
// ASCII character to PS/2 set-2 make/break byte stream (make, hold gap, F0h, code).
// Latency: first scan byte valid one cycle after the character handshake.
// Backpressure: SCAN_CODE/SCAN_VALID hold while SCAN_READY is low; ASCII_READY only in IDLE.
//
// Parameters: GAP_CYCLES - idle cycles between make-byte transfer and F0h (0..255).
// Optional feature macro SHIFT_WRAP_EN: maps '(' ')' '"' wrapped in left-shift
// make/break (12h); when undefined those characters are reported as unmapped.
//
// Ports:
//   CLK, RESET                 - clock (rising edge), asynchronous active-low reset
//   ASCII_CODE/VALID/READY     - character input handshake
//   SCAN_CODE/VALID/READY      - scan byte output handshake
//   BUSY                       - a sequence is in progress
//   ERROR                      - one-cycle pulse: accepted character has no mapping
module ascii2scan_tx #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] ASCII_CODE,
    input  logic       ASCII_VALID,
    output logic       ASCII_READY,
    output logic [7:0] SCAN_CODE,
    output logic       SCAN_VALID,
    input  logic       SCAN_READY,
    output logic       BUSY,
    output logic       ERROR
);

    localparam logic [7:0] GAP       = 8'(GAP_CYCLES);
    localparam logic [7:0] BRK_PFX   = 8'hF0;
`ifdef SHIFT_WRAP_EN
    localparam logic [7:0] LSHIFT    = 8'h12;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAKE,
        S_HOLD,
        S_BRK_F0,
        S_BRK_CODE
`ifdef SHIFT_WRAP_EN
        ,
        S_SH_MAKE,
        S_SH_BRK_F0,
        S_SH_BRK_CODE
`endif
    } state_t;

    // Returns {mapped, set-2 code}; letters are case-folded first.
    function automatic logic [8:0] lookup(input logic [7:0] c);
        logic [7:0] f;
        f = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
        case (f)
            8'h31: lookup = {1'b1, 8'h16};
            8'h32: lookup = {1'b1, 8'h1E};
            8'h33: lookup = {1'b1, 8'h26};
            8'h34: lookup = {1'b1, 8'h25};
            8'h35: lookup = {1'b1, 8'h2E};
            8'h36: lookup = {1'b1, 8'h36};
            8'h37: lookup = {1'b1, 8'h3D};
            8'h38: lookup = {1'b1, 8'h3E};
            8'h39: lookup = {1'b1, 8'h46};
            8'h30: lookup = {1'b1, 8'h45};
            8'h41: lookup = {1'b1, 8'h1C};
            8'h42: lookup = {1'b1, 8'h32};
            8'h43: lookup = {1'b1, 8'h21};
            8'h44: lookup = {1'b1, 8'h23};
            8'h45: lookup = {1'b1, 8'h24};
            8'h46: lookup = {1'b1, 8'h2B};
            8'h47: lookup = {1'b1, 8'h34};
            8'h48: lookup = {1'b1, 8'h33};
            8'h49: lookup = {1'b1, 8'h43};
            8'h4A: lookup = {1'b1, 8'h3B};
            8'h4B: lookup = {1'b1, 8'h42};
            8'h4C: lookup = {1'b1, 8'h4B};
            8'h4D: lookup = {1'b1, 8'h3A};
            8'h4E: lookup = {1'b1, 8'h31};
            8'h4F: lookup = {1'b1, 8'h44};
            8'h50: lookup = {1'b1, 8'h4D};
            8'h51: lookup = {1'b1, 8'h15};
            8'h52: lookup = {1'b1, 8'h2D};
            8'h53: lookup = {1'b1, 8'h1B};
            8'h54: lookup = {1'b1, 8'h2C};
            8'h55: lookup = {1'b1, 8'h3C};
            8'h56: lookup = {1'b1, 8'h2A};
            8'h57: lookup = {1'b1, 8'h1D};
            8'h58: lookup = {1'b1, 8'h22};
            8'h59: lookup = {1'b1, 8'h35};
            8'h5A: lookup = {1'b1, 8'h1A};
            8'h2D: lookup = {1'b1, 8'h4E};
            8'h3D: lookup = {1'b1, 8'h55};
            8'h2C: lookup = {1'b1, 8'h41};
            8'h2E: lookup = {1'b1, 8'h49};
            8'h2F: lookup = {1'b1, 8'h4A};
            8'h20: lookup = {1'b1, 8'h29};
            // keypad codes, sent without the E0 prefix
            8'h2B: lookup = {1'b1, 8'h79};
            8'h2A: lookup = {1'b1, 8'h7C};
`ifdef SHIFT_WRAP_EN
            8'h28: lookup = {1'b1, 8'h46};
            8'h29: lookup = {1'b1, 8'h45};
            8'h22: lookup = {1'b1, 8'h52};
`endif
            default: lookup = {1'b0, 8'h00};
        endcase
    endfunction

    state_t     r_state, w_nxt_state;
    logic [7:0] r_char,  w_nxt_char;
    logic [7:0] r_cnt,   w_nxt_cnt;
    logic [7:0] r_scan_code, w_nxt_code;
    logic       r_scan_vld,  w_nxt_vld;
    logic       r_ascii_rdy;
    logic       r_busy;
    logic       r_err,   w_nxt_err;
    logic [8:0] w_lk;
    logic       w_acc;
    logic       w_xfer;
`ifdef SHIFT_WRAP_EN
    logic       r_shift, w_nxt_shift;
    logic       w_is_shift;
    assign w_is_shift = (ASCII_CODE == 8'h28) || (ASCII_CODE == 8'h29) || (ASCII_CODE == 8'h22);
`endif

    assign w_lk   = lookup(ASCII_CODE);
    assign w_acc  = ASCII_VALID && r_ascii_rdy;
    assign w_xfer = r_scan_vld && SCAN_READY;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_char  = r_char;
        w_nxt_cnt   = r_cnt;
        w_nxt_code  = r_scan_code;
        w_nxt_vld   = r_scan_vld;
        w_nxt_err   = 1'b0;
`ifdef SHIFT_WRAP_EN
        w_nxt_shift = r_shift;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (w_lk[8]) begin
                        w_nxt_char  = w_lk[7:0];
                        w_nxt_vld   = 1'b1;
                        w_nxt_state = S_MAKE;
                        w_nxt_code  = w_lk[7:0];
`ifdef SHIFT_WRAP_EN
                        w_nxt_shift = w_is_shift;
                        if (w_is_shift) begin
                            w_nxt_state = S_SH_MAKE;
                            w_nxt_code  = LSHIFT;
                        end
`endif
                    end else begin
                        // unmapped: report and stay ready, no bytes
                        w_nxt_err = 1'b1;
                    end
                end
            end
            S_MAKE: begin
                if (w_xfer) begin
                    if (GAP == 8'd0) begin
                        w_nxt_state = S_BRK_F0;
                        w_nxt_code  = BRK_PFX;
                    end else begin
                        w_nxt_state = S_HOLD;
                        w_nxt_cnt   = GAP;
                        w_nxt_vld   = 1'b0;
                    end
                end
            end
            S_HOLD: begin
                // the F0h is presented in the cycle the counter reaches zero
                if (r_cnt <= 8'd1) begin
                    w_nxt_cnt   = 8'd0;
                    w_nxt_state = S_BRK_F0;
                    w_nxt_code  = BRK_PFX;
                    w_nxt_vld   = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt - 8'd1;
                end
            end
            S_BRK_F0: begin
                if (w_xfer) begin
                    w_nxt_state = S_BRK_CODE;
                    w_nxt_code  = r_char;
                end
            end
            S_BRK_CODE: begin
                if (w_xfer) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_vld   = 1'b0;
`ifdef SHIFT_WRAP_EN
                    if (r_shift) begin
                        w_nxt_state = S_SH_BRK_F0;
                        w_nxt_code  = BRK_PFX;
                        w_nxt_vld   = 1'b1;
                    end
`endif
                end
            end
`ifdef SHIFT_WRAP_EN
            S_SH_MAKE: begin
                if (w_xfer) begin
                    w_nxt_state = S_MAKE;
                    w_nxt_code  = r_char;
                end
            end
            S_SH_BRK_F0: begin
                if (w_xfer) begin
                    w_nxt_state = S_SH_BRK_CODE;
                    w_nxt_code  = LSHIFT;
                end
            end
            S_SH_BRK_CODE: begin
                if (w_xfer) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_vld   = 1'b0;
                end
            end
`endif
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_vld   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_char      <= 8'h00;
            r_cnt       <= 8'h00;
            r_scan_code <= 8'h00;
            r_scan_vld  <= 1'b0;
            r_ascii_rdy <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
`ifdef SHIFT_WRAP_EN
            r_shift     <= 1'b0;
`endif
        end else begin
            r_state     <= w_nxt_state;
            r_char      <= w_nxt_char;
            r_cnt       <= w_nxt_cnt;
            r_scan_code <= w_nxt_code;
            r_scan_vld  <= w_nxt_vld;
            // READY/BUSY are registered from the next state so they line up with it
            r_ascii_rdy <= (w_nxt_state == S_IDLE);
            r_busy      <= (w_nxt_state != S_IDLE);
            r_err       <= w_nxt_err;
`ifdef SHIFT_WRAP_EN
            r_shift     <= w_nxt_shift;
`endif
        end
    end

    assign ASCII_READY = r_ascii_rdy;
    assign SCAN_CODE   = r_scan_code;
    assign SCAN_VALID  = r_scan_vld;
    assign BUSY        = r_busy;
    assign ERROR       = r_err;

endmodule

// File: tb/tb_ascii2scan_tx.sv
module tb_ascii2scan_tx;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] ASCII_CODE;
    logic       ASCII_VALID;
    logic       ASCII_READY;
    logic [7:0] SCAN_CODE;
    logic       SCAN_VALID;
    logic       SCAN_READY;
    logic       BUSY;
    logic       ERROR;

    // second instance with zero hold gap
    logic [7:0] a0_code;
    logic       a0_vld;
    logic       a0_rdy;
    logic [7:0] s0_code;
    logic       s0_vld;
    logic       s0_rdy;
    logic       b0_busy;
    logic       e0_err;

    always #5 CLK = ~CLK;

    ascii2scan_tx #(.GAP_CYCLES(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .ASCII_CODE(ASCII_CODE), .ASCII_VALID(ASCII_VALID), .ASCII_READY(ASCII_READY),
        .SCAN_CODE(SCAN_CODE), .SCAN_VALID(SCAN_VALID), .SCAN_READY(SCAN_READY),
        .BUSY(BUSY), .ERROR(ERROR)
    );

    ascii2scan_tx #(.GAP_CYCLES(0)) dut0 (
        .CLK(CLK), .RESET(RESET),
        .ASCII_CODE(a0_code), .ASCII_VALID(a0_vld), .ASCII_READY(a0_rdy),
        .SCAN_CODE(s0_code), .SCAN_VALID(s0_vld), .SCAN_READY(s0_rdy),
        .BUSY(b0_busy), .ERROR(e0_err)
    );

    typedef struct {
        logic [7:0]      ch;
        int              nb;
        logic [5:0][7:0] b;
        int              err;
        int              rdy_k;
        int              gap;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got_q[$];
    int         err_n;
    int         rdy_k;
    int         gap_n;
    vec_t       tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] ch, input int nb,
                                input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                                input int err, input int rk, input int gap);
        vec_t v;
        v.ch = ch; v.nb = nb; v.err = err; v.rdy_k = rk; v.gap = gap;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4; v.b[5] = b5;
        return v;
    endfunction

    // Sends one character to dut and records transferred bytes, ERROR pulses,
    // the cycle (after the accept edge) at which ASCII_READY returns, and the
    // number of idle output cycles inside the sequence. 'stall' holds SCAN_READY
    // low for that many cycles when F0h is first presented.
    task automatic send(input logic [7:0] c, input int stall);
        int  stall_left;
        bit  stalling;
        bit  stalled_once;
        got_q.delete();
        err_n = 0; rdy_k = -1; gap_n = 0;
        stall_left = 0; stalling = 0; stalled_once = 0;
        @(negedge CLK);
        chk("ready_before_accept", ASCII_READY, 1'b1);
        ASCII_CODE = c; ASCII_VALID = 1'b1; SCAN_READY = 1'b1;
        @(posedge CLK); #1;
        ASCII_VALID = 1'b0;
        ASCII_CODE  = 8'h35;   // changing data while busy must be ignored
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (ERROR) err_n++;
            if (ASCII_READY) begin
                rdy_k = k;
                break;
            end
            if (!SCAN_VALID) begin
                if (got_q.size() > 0) gap_n++;
            end else if (stalling) begin
                chk("stall_hold", {23'd0, SCAN_VALID, SCAN_CODE}, {23'd0, 1'b1, 8'hF0});
                stall_left--;
                if (stall_left == 0) begin
                    stalling = 0;
                    SCAN_READY = 1'b1;
                    got_q.push_back(SCAN_CODE);
                end
            end else if (SCAN_CODE == 8'hF0 && stall > 0 && !stalled_once) begin
                stalling = 1; stalled_once = 1; stall_left = stall;
                SCAN_READY = 1'b0;
            end else begin
                got_q.push_back(SCAN_CODE);
            end
        end
        SCAN_READY = 1'b1;
        if (rdy_k < 0) begin
            errors++; checks++;
            $display("FAIL timeout: ASCII_READY never returned for char %0h", c);
        end
    endtask

    task automatic check_bytes(input string name, input int nb, input logic [5:0][7:0] b);
        chk({name, "_count"}, got_q.size(), nb);
        for (int i = 0; i < nb && i < got_q.size(); i++)
            chk({name, "_byte"}, got_q[i], b[i]);
    endtask

    initial begin
        logic [5:0][7:0] eb;
        bit found;

        tbl[0]  = mk(8'h41, 3, 8'h1C, 8'hF0, 8'h1C, 8'h00, 8'h00, 8'h00, 0, 8, 4); // 'A'
        tbl[1]  = mk(8'h62, 3, 8'h32, 8'hF0, 8'h32, 8'h00, 8'h00, 8'h00, 0, 8, 4); // 'b'
        tbl[2]  = mk(8'h31, 3, 8'h16, 8'hF0, 8'h16, 8'h00, 8'h00, 8'h00, 0, 8, 4); // '1'
        tbl[3]  = mk(8'h39, 3, 8'h46, 8'hF0, 8'h46, 8'h00, 8'h00, 8'h00, 0, 8, 4); // '9'
        tbl[4]  = mk(8'h2D, 3, 8'h4E, 8'hF0, 8'h4E, 8'h00, 8'h00, 8'h00, 0, 8, 4); // '-'
        tbl[5]  = mk(8'h20, 3, 8'h29, 8'hF0, 8'h29, 8'h00, 8'h00, 8'h00, 0, 8, 4); // space
        tbl[6]  = mk(8'h2A, 3, 8'h7C, 8'hF0, 8'h7C, 8'h00, 8'h00, 8'h00, 0, 8, 4); // '*'
        tbl[7]  = mk(8'h3D, 3, 8'h55, 8'hF0, 8'h55, 8'h00, 8'h00, 8'h00, 0, 8, 4); // '='
        tbl[8]  = mk(8'h2F, 3, 8'h4A, 8'hF0, 8'h4A, 8'h00, 8'h00, 8'h00, 0, 8, 4); // '/'
        tbl[9]  = mk(8'h7E, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0); // '~'
        tbl[10] = mk(8'h40, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0); // '@'
`ifdef SHIFT_WRAP_EN
        tbl[11] = mk(8'h28, 6, 8'h12, 8'h46, 8'hF0, 8'h46, 8'hF0, 8'h12, 0, 11, 4); // '('
        tbl[12] = mk(8'h22, 6, 8'h12, 8'h52, 8'hF0, 8'h52, 8'hF0, 8'h12, 0, 11, 4); // '"'
`else
        tbl[11] = mk(8'h28, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0);
        tbl[12] = mk(8'h22, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0);
`endif

        RESET = 1'b0; ASCII_CODE = 8'h00; ASCII_VALID = 1'b0; SCAN_READY = 1'b1;
        a0_code = 8'h00; a0_vld = 1'b0; s0_rdy = 1'b1;

        // reset state
        repeat (2) @(negedge CLK);
        chk("rst_ascii_ready", ASCII_READY, 1'b0);
        chk("rst_scan_valid", SCAN_VALID, 1'b0);
        chk("rst_scan_code", SCAN_CODE, 8'h00);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_error", ERROR, 1'b0);
        chk("rst_ready_gap0", a0_rdy, 1'b0);
        RESET = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", ASCII_READY, 1'b1);
        chk("post_rst_ready_gap0", a0_rdy, 1'b1);

        // table-driven characters with SCAN_READY held high
        for (int i = 0; i < 13; i++) begin
            send(tbl[i].ch, 0);
            check_bytes("tbl_bytes", tbl[i].nb, tbl[i].b);
            chk("tbl_error", err_n, tbl[i].err);
            chk("tbl_ready_cycle", rdy_k, tbl[i].rdy_k);
            chk("tbl_gap", gap_n, tbl[i].gap);
            @(negedge CLK);
            chk("tbl_error_clear", ERROR, 1'b0);
            chk("tbl_busy_idle", BUSY, 1'b0);
            chk("tbl_valid_idle", SCAN_VALID, 1'b0);
        end

        // 'z' with SCAN_READY low for 3 cycles while F0h is presented
        send(8'h7A, 3);
        eb = '0; eb[0] = 8'h1A; eb[1] = 8'hF0; eb[2] = 8'h1A;
        check_bytes("z_stall", 3, eb);
        chk("z_stall_ready_cycle", rdy_k, 11);

        // '~' unmapped followed by '5'
        send(8'h7E, 0);
        chk("tilde_error", err_n, 1);
        chk("tilde_no_bytes", got_q.size(), 0);
        chk("tilde_ready", ASCII_READY, 1'b1);
        send(8'h35, 0);
        eb = '0; eb[0] = 8'h2E; eb[1] = 8'hF0; eb[2] = 8'h2E;
        check_bytes("five", 3, eb);
        chk("five_error", err_n, 0);

        // '+' with reset pulsed right after the F0h transfer
        @(negedge CLK);
        ASCII_CODE = 8'h2B; ASCII_VALID = 1'b1; SCAN_READY = 1'b1;
        @(posedge CLK); #1;
        ASCII_VALID = 1'b0;
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (SCAN_VALID && SCAN_CODE == 8'hF0) begin
                found = 1;
                break;
            end
        end
        chk("plus_f0_seen", found, 1'b1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        #1;
        chk("plus_rst_valid", SCAN_VALID, 1'b0);
        chk("plus_rst_code", SCAN_CODE, 8'h00);
        chk("plus_rst_busy", BUSY, 1'b0);
        chk("plus_rst_ready", ASCII_READY, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("plus_after_valid", SCAN_VALID, 1'b0);
            chk("plus_after_ready", ASCII_READY, 1'b1);
        end

        // zero-gap instance: '0' gives 45, F0, 45 on consecutive cycles
        @(negedge CLK);
        a0_code = 8'h30; a0_vld = 1'b1;
        @(posedge CLK); #1;
        a0_vld = 1'b0;
        eb = '0; eb[0] = 8'h45; eb[1] = 8'hF0; eb[2] = 8'h45;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("gap0_byte", {23'd0, s0_vld, s0_code}, {23'd0, 1'b1, eb[k]});
        end
        @(negedge CLK);
        chk("gap0_ready", a0_rdy, 1'b1);
        chk("gap0_valid_end", s0_vld, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
